// File: rtl/lut_layer_sequencer_if.sv
// Handshake and table-programming bundle between a layer sequencer and its neighbours.
// The master side drives the input vector, table writes and out_ready; the slave is the sequencer.
interface lut_layer_sequencer_if #(
    parameter int NUM_NEURONS = 8,
    parameter int FAN_IN      = 6,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_NEURONS*FAN_IN-1:0] in_addrs;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_NEURONS-1:0]        out_data;
    logic                          cfg_we;
    logic [IDX_W+FAN_IN-1:0]       cfg_addr;
    logic                          cfg_data;
    logic                          cfg_ready;

    modport master (
        output in_valid, in_addrs, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_valid, out_data, cfg_ready
    );

    modport slave (
        input  in_valid, in_addrs, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_valid, out_data, cfg_ready
    );
endinterface

// File: rtl/lut_layer_sequencer.sv
// Purpose: evaluates one LogicNets layer serially from a shared runtime-programmable LUT table.
// Latency: out_valid rises NUM_NEURONS cycles after the accepting edge; one neuron per cycle.
// Backpressure: holds result in DONE until out_ready; in_ready/cfg_ready low whenever busy.
module lut_layer_sequencer #(
    parameter int NUM_NEURONS = 8,
    parameter int FAN_IN      = 6,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    lut_layer_sequencer_if.slave  bus,
    output logic                  busy
);
    localparam int ENTRIES = NUM_NEURONS << FAN_IN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q;
    logic [NUM_NEURONS*FAN_IN-1:0] addrs_q;
    logic [NUM_NEURONS-1:0]        out_q;
    logic                          tbl [ENTRIES];

    logic [FAN_IN-1:0]             addr_arr [NUM_NEURONS];
    logic [IDX_W-1:0]              cfg_idx;
    logic                          cfg_in_range;
    logic                          last_idx;
    logic                          accept;
    logic                          rd_bit;

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_unpack
        assign addr_arr[k] = addrs_q[k*FAN_IN +: FAN_IN];
    end

    assign cfg_idx      = bus.cfg_addr[IDX_W+FAN_IN-1 -: IDX_W];
    assign cfg_in_range = (32'(cfg_idx) < NUM_NEURONS);
    assign last_idx     = (idx_q == IDX_W'(NUM_NEURONS - 1));
    assign accept       = (state_q == IDLE) && bus.in_valid && !bus.cfg_we;
    assign rd_bit       = tbl[{idx_q, addr_arr[idx_q]}];

    // Table has no reset so programmed contents survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == IDLE && bus.cfg_we && cfg_in_range) begin
            tbl[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addrs_q <= bus.in_addrs;
                idx_q   <= '0;
            end else if (state_q == RUN) begin
                out_q[idx_q] <= rd_bit;
                idx_q        <= last_idx ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                bus.in_ready  = !bus.cfg_we;
                if (accept) state_d = RUN;
            end
            RUN: begin
                if (last_idx) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_data = out_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Scoreboarded bench for lut_layer_sequencer: a reference table model predicts each vector's result.
module tb_lut_layer_sequencer;
    localparam int N = 8;
    localparam int F = 6;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    lut_layer_sequencer_if #(.NUM_NEURONS(N), .FAN_IN(F)) bus ();

    lut_layer_sequencer #(.NUM_NEURONS(N), .FAN_IN(F)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    logic           model [N*64];
    logic [N-1:0]   sb [$];
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [N*F-1:0] vec1, vec_id, vec_zero;

    function automatic logic [N-1:0] expect_of(input logic [N*F-1:0] v);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = model[k*64 + int'(v[k*F +: F])];
        return r;
    endfunction

    // Called at a negedge while the DUT is IDLE.
    task automatic cfg_write(input int k, input int a, input logic d);
        bus.cfg_we = 1'b1; bus.cfg_addr = 9'(k*64 + a); bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        model[k*64 + a] = d;
    endtask

    task automatic accept(input logic [N*F-1:0] v, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1; bus.in_addrs = v;
        for (int i = 0; i < 64 && !ok; i++) begin
            #1;
            if (bus.in_ready === 1'b1) begin
                sb.push_back(expect_of(v));
                ok = 1'b1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output logic [N-1:0] dat, output bit ok);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        ok  = (bus.out_valid === 1'b1);
        dat = bus.out_data;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", bus.out_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", bus.cfg_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_eval();
        bit ok; int lat; logic [N-1:0] dat, exp;
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 64; a++) cfg_write(k, a, (a == k));
        accept(vec1, ok);
        n_checks++; if (!ok) $display("FAIL eval_accept: got no accept want accept"); else n_pass++;
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok) $display("FAIL eval_out_valid: got timeout want out_valid"); else n_pass++;
        n_checks++; if (lat !== 8) $display("FAIL eval_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (dat !== exp) $display("FAIL eval_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat !== 8'h55) $display("FAIL eval_data: got %h want 55", dat); else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok; int lat; logic [N-1:0] dat, exp;
        accept(vec1, ok);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); else n_pass++;
        exp = pop_exp();
        bus.in_valid = 1'b1; bus.in_addrs = vec_zero;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (bus.out_data !== exp) $display("FAIL bp_hold_data: got %h want %h", bus.out_data, exp); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else n_pass++;
            n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid_hold: got %b want 1", bus.out_valid); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (bus.out_data !== 8'h55) $display("FAIL bp_data: got %h want 55", bus.out_data); else n_pass++;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else n_pass++;
        sb.push_back(expect_of(vec_zero));
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok || lat !== 8) $display("FAIL bp_second_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (dat !== exp) $display("FAIL bp_second_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat !== 8'h01) $display("FAIL bp_second_data: got %h want 01", dat); else n_pass++;
    endtask

    task automatic test_cfg_during_run();
        bit ok; int lat; logic [N-1:0] dat, exp;
        accept(vec1, ok);
        bus.cfg_we = 1'b1; bus.cfg_addr = 9'(3*64 + 3); bus.cfg_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.cfg_ready !== 1'b0) $display("FAIL run_cfg_ready: got %b want 0", bus.cfg_ready); else n_pass++;
            n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL run_in_ready: got %b want 0", bus.in_ready); else n_pass++;
            @(negedge clk);
        end
        bus.cfg_we = 1'b0;
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok || dat !== exp) $display("FAIL run_cfg_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat !== 8'h55) $display("FAIL run_cfg_data: got %h want 55", dat); else n_pass++;
        accept(vec_id, ok);
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok || dat !== exp) $display("FAIL run_cfg_ident_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat !== 8'hFF) $display("FAIL run_cfg_ident_data: got %h want ff", dat); else n_pass++;
    endtask

    task automatic test_cfg_and_input();
        bit ok; int lat; logic [N-1:0] dat, exp;
        bus.cfg_we = 1'b1; bus.cfg_addr = 9'd0; bus.cfg_data = 1'b0;
        bus.in_valid = 1'b1; bus.in_addrs = vec1;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL cfgin_in_ready_blocked: got %b want 0", bus.in_ready); else n_pass++;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        model[0] = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL cfgin_in_ready_next: got %b want 1", bus.in_ready); else n_pass++;
        sb.push_back(expect_of(vec1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok || lat !== 8) $display("FAIL cfgin_latency: got %0d want 8", lat); else n_pass++;
        n_checks++; if (dat !== exp) $display("FAIL cfgin_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat[0] !== 1'b0) $display("FAIL cfgin_bit0: got %b want 0", dat[0]); else n_pass++;
        cfg_write(0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        bit ok; int lat; logic [N-1:0] dat, exp;
        accept(vec1, ok);
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rstrun_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstrun_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.out_data !== 8'h00) $display("FAIL rstrun_out_data: got %h want 00", bus.out_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstrun_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstrun_in_ready: got %b want 1", bus.in_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        accept(vec1, ok);
        wait_out(lat, dat, ok);
        exp = pop_exp();
        n_checks++; if (!ok || dat !== exp) $display("FAIL rstrun_rerun_scoreboard: got %h want %h", dat, exp); else n_pass++;
        n_checks++; if (dat !== 8'h55) $display("FAIL rstrun_rerun_data: got %h want 55", dat); else n_pass++;
    endtask

    task automatic test_boundaries();
        bit ok; int lat; logic [N-1:0] dat, exp; logic [N*F-1:0] v;
        int   addr_t [3] = '{0, 63, 62};
        logic bit_t  [3] = '{1'b1, 1'b1, 1'b0};
        for (int a = 0; a < 64; a++) cfg_write(7, a, (a == 0 || a == 63));
        for (int i = 0; i < 3; i++) begin
            v = vec1;
            v[7*F +: F] = 6'(addr_t[i]);
            accept(v, ok);
            wait_out(lat, dat, ok);
            exp = pop_exp();
            n_checks++; if (!ok || dat !== exp) $display("FAIL bound_scoreboard_%0d: got %h want %h", addr_t[i], dat, exp); else n_pass++;
            n_checks++; if (dat[7] !== bit_t[i]) $display("FAIL bound_bit7_addr%0d: got %b want %b", addr_t[i], dat[7], bit_t[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; logic [N-1:0] dat, exp; logic [N*F-1:0] v;
        for (int e = 0; e < N*64; e++) cfg_write(e / 64, e % 64, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) v[k*F +: F] = 6'($urandom_range(0, 63));
            accept(v, ok);
            wait_out(lat, dat, ok);
            exp = pop_exp();
            n_checks++; if (!ok || lat !== 8) $display("FAIL rand_latency_%0d: got %0d want 8", i, lat); else n_pass++;
            n_checks++; if (dat !== exp) $display("FAIL rand_data_%0d: got %h want %h", i, dat, exp); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_addrs = '0; bus.out_ready = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = 1'b0;
        for (int k = 0; k < N; k++) begin
            vec1[k*F +: F]     = (k % 2 == 0) ? 6'(k) : 6'd63;
            vec_id[k*F +: F]   = 6'(k);
            vec_zero[k*F +: F] = 6'd0;
        end
        @(negedge clk);
        test_reset();
        test_eval();
        test_backpressure();
        test_cfg_during_run();
        test_cfg_and_input();
        test_reset_mid_run();
        test_boundaries();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
